pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core; drives the write-enable and flush of the IF/ID register, the PC write-enable and the ID/EX bubble.
//  Detects load-use hazards, taken-branch/jump redirects and HI/LO conflicts while the multi-cycle mult/div unit is busy.
//  Sits beside the ID stage; consumes decoded ID fields plus EX-stage status.
// PARAMETERS
//  MULDIV_LAT  32  cycles mult/div occupies HI/LO after start (>=2)
//  CNT_W       32  width of optional statistics counters
// PORTS
//  clk             in   1   core clock, rising edge
//  rst             in   1   asynchronous, active-low reset
//  id_rs           in   5   rs field of instruction in ID
//  id_rt           in   5   rt field of instruction in ID
//  id_use_rs       in   1   ID instruction reads rs
//  id_use_rt       in   1   ID instruction reads rt
//  id_use_hilo     in   1   ID instr is mfhi/mflo/mthi/mtlo/mult/div
//  ex_memread      in   1   EX instruction is a load
//  ex_rt           in   5   load destination register in EX
//  ex_redirect     in   1   taken branch or jump resolved in EX
//  ex_muldiv_start in   1   mult/div issues in EX this cycle
//  pc_we           out  1   PC register write enable
//  ifid_we         out  1   IF/ID register write enable
//  ifid_flush      out  1   IF/ID loads NOP (0x0000_0000) next edge
//  idex_bubble     out  1   ID/EX loads NOP next edge
//  muldiv_busy     out  1   HI/LO result pending
//  stall_cnt       out  CNT_W  stall cycles (HAZARD_STATS_EN only)
//  flush_cnt       out  CNT_W  flush events (HAZARD_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0, stats=0; outputs forced pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, muldiv_busy=0.
//  - FSM states: IDLE, MD_BUSY. IDLE->MD_BUSY on ex_muldiv_start (cnt<=MULDIV_LAT-1).
//    MD_BUSY: cnt decrements each cycle; cnt==0 -> IDLE next edge. muldiv_busy=1 iff MD_BUSY.
//  - ex_muldiv_start in MD_BUSY is a protocol error; it cannot occur because hilo stall blocks issue. Ignore it; no restart.
//  - Outputs are combinational from state plus inputs; zero added latency.
//  - load_use = ex_memread & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
//  - hilo_stall = muldiv_busy & id_use_hilo.
//  - Priority, highest first:
//    1 ex_redirect: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1 (kills ID+IF wrong-path instrs; overrides any stall).
//    2 hilo_stall:  pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
//    3 load_use:    same as hilo_stall; lasts exactly 1 cycle (load advances to MEM).
//    4 else:        pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
//  - Register $0 never causes a load-use stall.
//  - Last busy cycle (cnt==0) still stalls hilo users; they proceed the following cycle.
//  - Reset mid-MD_BUSY aborts countdown; IDLE on release.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//   - stall_cnt increments on each cycle with priority 2 or 3 active.
//   - flush_cnt increments on each ex_redirect cycle.
//   - Both counters saturate at all-ones and clear on reset.
//  HAZARD_STATS_EN undefined: stall_cnt/flush_cnt tied to 0 and no counter flops exist.
// STRUCTURE
//  - Shared package mips_pipe_pkg: state enum (IDLE, MD_BUSY), REG_ZERO=5'd0, NOP_INSTR=32'h0.
//  - One sub-module, muldiv_busy_tracker, holds the FSM and down-counter and outputs muldiv_busy.
//  - Hazard priority logic and stats counters stay in the top module.
// TESTING
//  - Reset: hold rst=0 for 3 clk -> pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1; on release with no hazards -> all enables 1, flush/bubble 0.
//  - Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_use_rs=1 -> exactly 1 cycle with pc_we=0, ifid_we=0, idex_bubble=1; the same with ex_rt=0 -> no stall.
//  - Redirect over stall: ex_redirect=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_we=1.
//  - Mult/div, MULDIV_LAT=4: ex_muldiv_start pulse, then mflo held in ID -> muldiv_busy=1 for 4 cycles, ifid_we=0 for those 4, mflo proceeds cycle 5.
//  - Reset mid-busy: assert rst=0 at busy cycle 2 -> muldiv_busy=0 immediately; after release, mflo not stalled.
//  - Stats (HAZARD_STATS_EN): 3 load-use stalls plus 2 redirects -> stall_cnt=3, flush_cnt=2; with CNT_W=2 and 5 stalls -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
//   Shared definitions for the MIPS pipeline control slice.
//   - md_state_e : mult/div busy tracker state encoding (IDLE, MD_BUSY)
//   - REG_ZERO   : architectural $zero register index
//   - NOP_INSTR  : instruction word loaded into a flushed pipeline register
package mips_pipe_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/muldiv_busy_tracker.sv
// muldiv_busy_tracker
//   Tracks how long the multi-cycle mult/div unit owns HI/LO after issue.
//   A start pulse loads a down-counter with MULDIV_LAT-1; the tracker stays
//   busy until the counter reaches its terminal count of zero, so busy is
//   asserted for exactly MULDIV_LAT cycles.
// Ports
//   i_clk    core clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  mult/div issues this cycle (ignored while already busy)
//   o_busy   HI/LO result pending
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | HI/LO free, waiting for a mult/div issue
// MD_BUSY | mult/div in flight, counter runs down to zero
module muldiv_busy_tracker
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_busy
);

  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [0:0]    S_IDLE    = IDLE;
  localparam logic [0:0]    S_MD_BUSY = MD_BUSY;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(MULDIV_LAT - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_MD_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_MD_BUSY: begin
          // A second start while busy cannot legally happen (hilo stall
          // blocks issue), so it is ignored rather than restarting.
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state == S_MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer beside the ID stage of the 5-stage MIPS core. Detects
//   load-use hazards, taken branch/jump redirects resolved in EX and HI/LO
//   conflicts while mult/div is busy, and drives PC/IF-ID enables, the IF/ID
//   flush and the ID/EX bubble. Outputs are combinational (no added latency).
//   Optional statistics counters are built only when HAZARD_STATS_EN is
//   defined; otherwise stall_cnt/flush_cnt are tied to zero.
// Ports
//   clk, rst                 core clock; asynchronous active-low reset
//   id_rs/id_rt, id_use_*    decoded ID source registers and usage flags
//   ex_memread, ex_rt        EX load and its destination register
//   ex_redirect              taken branch/jump resolved in EX
//   ex_muldiv_start          mult/div issues in EX this cycle
//   pc_we, ifid_we           PC and IF/ID write enables
//   ifid_flush, idex_bubble  IF/ID loads NOP, ID/EX loads NOP
//   muldiv_busy              HI/LO result pending
//   stall_cnt, flush_cnt     saturating stall-cycle / redirect counters
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_use_hilo,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             ex_muldiv_start,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic w_busy;
  logic w_load_use;
  logic w_hilo_stall;
  logic w_stall;

  muldiv_busy_tracker #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_busy_tracker (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_start (ex_muldiv_start),
    .o_busy  (w_busy)
  );

  assign muldiv_busy = w_busy;

  // $zero is hardwired, so a load targeting it never produces a dependency.
  assign w_load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rt)) ||
                       (id_use_rt && (id_rt == ex_rt)));

  // The last busy cycle still stalls; HI/LO consumers proceed the cycle after.
  assign w_hilo_stall = w_busy && id_use_hilo;
  assign w_stall      = w_hilo_stall || w_load_use;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      // Hold the front end and keep NOPs in the pipe while in reset.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_redirect) begin
      // Redirect wins over stalls: the stalled ID instruction is on the
      // wrong path anyway, so kill both IF and ID and let the PC load.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Stall cycles are counted only when the stall is actually applied,
  // i.e. not overridden by a redirect in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (ex_redirect) begin
        if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_stall) begin
        if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
